// File: rtl/ps2_digit_entry.sv
// PS/2 scan-code-set-2 digit entry buffer: collects BCD digits with backspace, escape and enter.
// Optional macro PS2_DIGIT_NUMPAD_EN adds numpad digits and keypad enter (E0 5A).
module ps2_digit_entry #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned OVERWRITE  = 0,
    localparam int unsigned CNT_W     = $clog2(NUM_DIGITS + 1),
    localparam int unsigned DW        = 4 * NUM_DIGITS
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [7:0]       keycode_i,
    input  logic             rx_done_i,
    output logic [DW-1:0]    digits_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic [DW-1:0]    number_o,
    output logic             done_o
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_param_check
        $error("NUM_DIGITS must be in 1..8");
    end

    typedef enum logic [1:0] {StIdle, StExt, StBreak} state_e;

    localparam logic [7:0] KeyBreak = 8'hF0;
    localparam logic [7:0] KeyExt   = 8'hE0;
    localparam logic [7:0] KeyBksp  = 8'h66;
    localparam logic [7:0] KeyEnter = 8'h5A;
    localparam logic [7:0] KeyEsc   = 8'h76;

    state_e           state_q, state_d;
    logic             rx_q;
    logic             ev;
    logic [DW-1:0]    digits_q, digits_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DW-1:0]    number_q, number_d;
    logic             done_q, done_d;

    logic             act_digit, act_bksp, act_enter, act_esc;
    logic [4:0]       key_dec;
    logic [DW-1:0]    digit_ext;
    logic             is_full;

    // Returns {valid, bcd} for a make code that enters a digit.
    function automatic logic [4:0] decode_digit(input logic [7:0] code);
        logic [4:0] r;
        r = 5'b0;
        unique case (code)
            8'h45: r = {1'b1, 4'd0};
            8'h16: r = {1'b1, 4'd1};
            8'h1E: r = {1'b1, 4'd2};
            8'h26: r = {1'b1, 4'd3};
            8'h25: r = {1'b1, 4'd4};
            8'h2E: r = {1'b1, 4'd5};
            8'h36: r = {1'b1, 4'd6};
            8'h3D: r = {1'b1, 4'd7};
            8'h3E: r = {1'b1, 4'd8};
            8'h46: r = {1'b1, 4'd9};
`ifdef PS2_DIGIT_NUMPAD_EN
            8'h70: r = {1'b1, 4'd0};
            8'h69: r = {1'b1, 4'd1};
            8'h72: r = {1'b1, 4'd2};
            8'h7A: r = {1'b1, 4'd3};
            8'h6B: r = {1'b1, 4'd4};
            8'h73: r = {1'b1, 4'd5};
            8'h74: r = {1'b1, 4'd6};
            8'h6C: r = {1'b1, 4'd7};
            8'h75: r = {1'b1, 4'd8};
            8'h7D: r = {1'b1, 4'd9};
`endif
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    // A held rx_done produces a single event on its rising edge.
    assign ev = rx_done_i & ~rx_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ev) begin
            unique case (state_q)
                StIdle: begin
                    if (keycode_i == KeyBreak) begin
                        state_d = StBreak;
                    end else if (keycode_i == KeyExt) begin
                        state_d = StExt;
                    end
                end
                StExt:   state_d = (keycode_i == KeyBreak) ? StBreak : StIdle;
                StBreak: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        key_dec   = decode_digit(keycode_i);
        act_digit = 1'b0;
        act_bksp  = 1'b0;
        act_enter = 1'b0;
        act_esc   = 1'b0;
        if (ev && state_q == StIdle) begin
            act_digit = key_dec[4];
            act_bksp  = (keycode_i == KeyBksp);
            act_enter = (keycode_i == KeyEnter);
            act_esc   = (keycode_i == KeyEsc);
        end
`ifdef PS2_DIGIT_NUMPAD_EN
        if (ev && state_q == StExt && keycode_i == KeyEnter) begin
            act_enter = 1'b1;
        end
`endif
    end

    assign is_full = (count_q == CNT_W'(NUM_DIGITS));

    always_comb begin
        digit_ext      = '0;
        digit_ext[3:0] = key_dec[3:0];
        digits_d       = digits_q;
        count_d        = count_q;
        number_d       = number_q;
        done_d         = 1'b0;
        if (act_digit) begin
            if (!is_full) begin
                digits_d = (digits_q << 4) | digit_ext;
                count_d  = count_q + CNT_W'(1);
            end else if (OVERWRITE != 0) begin
                digits_d = (digits_q << 4) | digit_ext;
            end
        end else if (act_bksp) begin
            if (count_q != '0) begin
                digits_d = digits_q >> 4;
                count_d  = count_q - CNT_W'(1);
            end
        end else if (act_esc) begin
            digits_d = '0;
            count_d  = '0;
        end else if (act_enter) begin
            number_d = digits_q;
            digits_d = '0;
            count_d  = '0;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_q     <= 1'b0;
            digits_q <= '0;
            count_q  <= '0;
            number_q <= '0;
            done_q   <= 1'b0;
        end else begin
            rx_q     <= rx_done_i;
            digits_q <= digits_d;
            count_q  <= count_d;
            number_q <= number_d;
            done_q   <= done_d;
        end
    end

    assign digits_o = digits_q;
    assign count_o  = count_q;
    assign full_o   = is_full;
    assign number_o = number_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Directed self-checking bench for ps2_digit_entry; a second instance runs with OVERWRITE=1.
module tb_ps2_digit_entry;

    logic        clk;
    logic        reset;
    logic [7:0]  keycode;
    logic        rx_done;

    logic [15:0] digits0, number0, digits1, number1;
    logic [2:0]  count0, count1;
    logic        full0, full1, done0, done1;

    int checks = 0;
    int errors = 0;

    ps2_digit_entry #(.NUM_DIGITS(4), .OVERWRITE(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .keycode_i(keycode), .rx_done_i(rx_done),
        .digits_o(digits0), .count_o(count0), .full_o(full0),
        .number_o(number0), .done_o(done0)
    );

    ps2_digit_entry #(.NUM_DIGITS(4), .OVERWRITE(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .keycode_i(keycode), .rx_done_i(rx_done),
        .digits_o(digits1), .count_o(count1), .full_o(full1),
        .number_o(number1), .done_o(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse rx_done for one cycle; returns on the negedge after the event edge.
    task automatic send(input logic [7:0] k);
        @(negedge clk);
        keycode = k;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; rx_done = 1'b0; keycode = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (digits0 !== 16'h0 || count0 !== 3'd0 || full0 !== 1'b0 ||
            number0 !== 16'h0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL reset: digits=%h count=%0d full=%b number=%h done=%b",
                     digits0, count0, full0, number0, done0);
        end
    endtask

    task automatic test_held_rx;
        @(negedge clk);
        keycode = 8'h16; rx_done = 1'b1;
        #40 keycode = 8'h1E;
        #40 keycode = 8'h26;
        #40 keycode = 8'h25;
        #40 rx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (digits0 !== 16'h0001 || count0 !== 3'd1) begin
            errors++;
            $display("FAIL held_rx: digits=%h count=%0d want 0001/1", digits0, count0);
        end
        send(8'h1E); send(8'h26); send(8'h25);
        checks++;
        if (digits0 !== 16'h1234 || count0 !== 3'd4 || full0 !== 1'b1) begin
            errors++;
            $display("FAIL pulse_entry: digits=%h count=%0d full=%b want 1234/4/1",
                     digits0, count0, full0);
        end
        send(8'h76);
        checks++;
        if (digits0 !== 16'h0 || count0 !== 3'd0 || full0 !== 1'b0) begin
            errors++;
            $display("FAIL escape_clear: digits=%h count=%0d full=%b", digits0, count0, full0);
        end
    endtask

    task automatic test_break_backspace;
        send(8'h16); send(8'hF0); send(8'h16);
        send(8'h1E); send(8'hF0); send(8'h1E);
        checks++;
        if (digits0 !== 16'h0012 || count0 !== 3'd2) begin
            errors++;
            $display("FAIL breaks_ignored: digits=%h count=%0d want 0012/2", digits0, count0);
        end
        send(8'h66);
        checks++;
        if (digits0 !== 16'h0001 || count0 !== 3'd1) begin
            errors++;
            $display("FAIL backspace: digits=%h count=%0d want 0001/1", digits0, count0);
        end
        send(8'h66); send(8'h66);
        checks++;
        if (digits0 !== 16'h0000 || count0 !== 3'd0) begin
            errors++;
            $display("FAIL backspace_underflow: digits=%h count=%0d want 0000/0",
                     digits0, count0);
        end
    endtask

    task automatic test_overwrite;
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h46);
        checks++;
        if (digits0 !== 16'h1234 || count0 !== 3'd4 || full0 !== 1'b1) begin
            errors++;
            $display("FAIL full_drop: digits=%h count=%0d full=%b want 1234/4/1",
                     digits0, count0, full0);
        end
        checks++;
        if (digits1 !== 16'h2349 || count1 !== 3'd4 || full1 !== 1'b1) begin
            errors++;
            $display("FAIL full_shift: digits=%h count=%0d full=%b want 2349/4/1",
                     digits1, count1, full1);
        end
        send(8'h76);
    endtask

    task automatic test_enter;
        send(8'h3D); send(8'h45);
        checks++;
        if (done0 !== 1'b0) begin
            errors++;
            $display("FAIL done_idle: done=%b want 0", done0);
        end
        send(8'h5A);
        checks++;
        if (number0 !== 16'h0070 || done0 !== 1'b1 || digits0 !== 16'h0 || count0 !== 3'd0) begin
            errors++;
            $display("FAIL enter: number=%h done=%b digits=%h count=%0d want 0070/1/0/0",
                     number0, done0, digits0, count0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || number0 !== 16'h0070) begin
            errors++;
            $display("FAIL done_width: done=%b number=%h want 0/0070", done0, number0);
        end
        send(8'h5A);
        checks++;
        if (number0 !== 16'h0000 || done0 !== 1'b1) begin
            errors++;
            $display("FAIL enter_empty: number=%h done=%b want 0000/1", number0, done0);
        end
    endtask

    task automatic test_reset_in_break;
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send(8'h16);
        checks++;
        if (digits0 !== 16'h0001 || count0 !== 3'd1) begin
            errors++;
            $display("FAIL reset_in_break: digits=%h count=%0d want 0001/1", digits0, count0);
        end
        send(8'h5A);
        send(8'h3E); send(8'h3E);
        send(8'h76);
        checks++;
        if (digits0 !== 16'h0 || count0 !== 3'd0 || number0 !== 16'h0001) begin
            errors++;
            $display("FAIL escape_keeps_number: digits=%h count=%0d number=%h want 0/0/0001",
                     digits0, count0, number0);
        end
    endtask

    task automatic test_numpad;
        logic [15:0] exp_num;
        logic [15:0] exp_dig;
        logic        exp_done;
`ifdef PS2_DIGIT_NUMPAD_EN
        exp_num  = 16'h0012;
        exp_done = 1'b1;
        exp_dig  = 16'h0001;
`else
        exp_num  = 16'h0001;
        exp_done = 1'b0;
        exp_dig  = 16'h0000;
`endif
        send(8'h69); send(8'h72); send(8'hE0); send(8'h5A);
        checks++;
        if (number0 !== exp_num || done0 !== exp_done || digits0 !== 16'h0) begin
            errors++;
            $display("FAIL numpad_enter: number=%h done=%b digits=%h want %h/%b/0000",
                     number0, done0, digits0, exp_num, exp_done);
        end
        send(8'h76);
        // Numpad release must be swallowed; only the make enters a digit.
        send(8'h69); send(8'hF0); send(8'h69);
        checks++;
        if (digits0 !== exp_dig) begin
            errors++;
            $display("FAIL numpad_break: digits=%h want %h", digits0, exp_dig);
        end
        send(8'hE0); send(8'hF0); send(8'h5A);
        checks++;
        if (done0 !== 1'b0 || digits0 !== exp_dig) begin
            errors++;
            $display("FAIL ext_break: done=%b digits=%h want 0/%h", done0, digits0, exp_dig);
        end
        send(8'h16);
        checks++;
        if (digits0 !== {exp_dig[11:0], 4'h1}) begin
            errors++;
            $display("FAIL after_ext_break: digits=%h want %h", digits0, {exp_dig[11:0], 4'h1});
        end
    endtask

    initial begin
        test_reset();
        test_held_rx();
        test_break_backspace();
        test_overwrite();
        test_enter();
        test_reset_in_break();
        test_numpad();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_digit_entry.md
Name: ps2_digit_entry

Overview:
- Collects decimal digits typed on a PS/2 keyboard into an N-digit BCD entry buffer.
- Decodes scan-code set 2 make/break/extended sequences. Supports backspace, escape-clear and enter-commit.
- Sits between the PS/2 receiver (keycode + rx_done) and the display/arithmetic logic.
- Generalised successor of the fixed four-digit number register.

Parameters:
- NUM_DIGITS, 4, number of BCD digits held (1..8).
- OVERWRITE, 0, full-buffer policy: 0 = drop new digit, 1 = shift out oldest digit.
- CNT_W (localparam), clog2(NUM_DIGITS+1), width of count.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- keycode  in  8  scan code byte from PS/2 receiver
- rx_done  in  1  byte-valid from receiver; may be a pulse or held high
- digits  out  4*NUM_DIGITS  live BCD buffer; [3:0] = most recent digit; unused digits = 0
- count  out  CNT_W  number of digits currently entered
- full  out  1  count == NUM_DIGITS
- number  out  4*NUM_DIGITS  committed value, same layout as digits, held until next enter
- done  out  1  one-cycle pulse after commit

Behaviour:
- Reset (async): digits=0, count=0, full=0, number=0, done=0, FSM=IDLE, rx_d=0.
- Event detect:
  - rx_d is a registered copy of rx_done.
  - event = rx_done & ~rx_d, so a held rx_done yields exactly one event.
  - At most one event per cycle. All actions below take effect at the clock edge where event=1 and are visible the next cycle.
  - keycode is sampled only on that edge.
- FSM states: IDLE, EXT (after E0), BREAK (after F0).
  - IDLE: F0 -> BREAK; E0 -> EXT; otherwise execute the code as a make code, stay IDLE.
  - EXT: F0 -> BREAK; otherwise execute it as an extended make code, -> IDLE.
  - BREAK: the code is consumed with no action, -> IDLE. Release never enters a digit.
- Make-code actions in IDLE (set 2):
  - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - 66 backspace; 5A enter; 76 escape. Any other code: no action.
- Extended make codes: no action, except as stated under Optional Feature.
- Digit entry, count<NUM_DIGITS:
  - digits <= {digits[4*NUM_DIGITS-5:0], d}; count+1.
- Digit entry, full:
  - OVERWRITE=0: ignored, no state change.
  - OVERWRITE=1: same shift (oldest digit lost); count stays NUM_DIGITS.
- Backspace: digits <= digits>>4, count-1. No-op when count=0.
- Escape: digits=0, count=0. number unchanged.
- Enter:
  - number <= digits; digits=0, count=0; done=1 for exactly the following cycle.
  - Enter with count=0 still commits 0 and pulses done.
- full is combinational from count.
- Typematic repeat (repeated make codes with no break) enters repeated digits.
- Reset asserted mid-sequence (e.g. in BREAK): FSM returns to IDLE and the pending byte is lost.

Optional Feature:
- Macro: PS2_DIGIT_NUMPAD_EN.
- Defined:
  - Numpad make codes in IDLE also enter digits: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
  - Extended 5A in EXT (keypad enter) acts as enter.
  - Their F0 releases are consumed as normal.
- Undefined:
  - Numpad codes are ignored.
  - Extended 5A is ignored.
  - Numpad break sequences are still consumed correctly by the FSM.

Test Plan:
- Reset, then hold rx_done=1 while stepping keycode 16,1E,26,25 at 40 ns intervals -> only one event; digits=0x0001, count=1. Then pulse rx_done per byte for 1E,26,25 -> digits=0x1234, count=4, full=1.
- NUM_DIGITS=4: codes 16,F0,16,1E,F0,1E -> digits=0x0012, count=2 (breaks ignored). Then 66 -> 0x0001, count=1. Then 66,66 -> 0x0000, count=0, no underflow.
- OVERWRITE=0 vs 1: enter 1,2,3,4 then 46 -> 0x1234 (dropped) vs 0x2349 (shifted); count=4 in both.
- 3D,45 then 5A -> number=0x0070, done high exactly 1 cycle, digits=0, count=0. Then 5A alone -> number=0x0000, done pulses.
- Assert reset while FSM in BREAK (after F0), release reset, send 16 -> digits=0x0001. Send 76 -> digits=0, count=0, number unchanged.
- With PS2_DIGIT_NUMPAD_EN: 69,72 then E0,5A -> number=0x0012, done pulses. Without the macro: same stimulus -> digits=0, no done.
